// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter: the frame format,
// the default baud divisor and the receive FSM state encoding.
// Optional feature: UART_RX_PARITY_EN (even parity bit after data bit 7).
// -----------------------------------------------------------------------------
package uart_pkg;

  // 50 MHz system clock / 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  // Frame format: 1 start bit, DATA_BITS data bits LSB-first, 1 stop bit.
  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  // Receive FSM states. ST_PARITY is reached only in parity builds.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  // Even parity: data bits plus the parity bit must XOR to zero.
  function automatic logic even_parity_bad(input logic [DATA_BITS-1:0] data,
                                           input logic                 par);
    return (^data) ^ par;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input. Both flops reset to
// RESET_VAL so the synchronised output matches the input's idle level from the
// first cycle after reset.
// Ports:
//   clk    in  1  destination clock
//   rst_n  in  1  asynchronous active-low reset
//   i_d    in  1  asynchronous input
//   o_q    out 1  synchronised output, 2 cycles latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make r_sync take the old r_meta, giving
      // a true two-stage pipeline; blocking here would collapse it to one flop.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver, 8N1 (or 8E1 with UART_RX_PARITY_EN defined). Synchronises
// the serial line, qualifies the start bit at half a bit period, samples each
// data bit at its centre, checks the stop bit and reports the byte with a
// one-cycle strobe. There is no backpressure: an untaken byte is overwritten.
// Build option: `define UART_RX_PARITY_EN enables the even-parity bit.
// Ports:
//   clk           in  1  system clock
//   rst_n         in  1  asynchronous active-low reset
//   rx            in  1  asynchronous serial line, idles high
//   rx_data       out 8  last good byte, updated only with rx_valid
//   rx_valid      out 1  one-cycle pulse on a good frame
//   frame_error   out 1  one-cycle pulse when the stop bit is sampled low
//   parity_error  out 1  one-cycle pulse on a parity mismatch (0 without option)
//   busy          out 1  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser; resets to the idle (high) line level.
  // ---------------------------------------------------------------------------
  logic w_rx_s;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  uart_state_e                r_state;
  uart_state_e                w_next_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [BIT_IDX_W-1:0]       r_bit_idx;
  logic [DATA_BITS-1:0]       r_shift;
  logic [DATA_BITS-1:0]       r_rx_data;
  logic                       r_rx_valid;
  logic                       r_frame_error;
  logic                       r_parity_error;

  // FSM control decoded from the current state.
  logic                       w_tick;        // counter reached this state's sample point
  logic                       w_cnt_clr;
  logic                       w_shift_en;
  logic                       w_set_valid;
  logic                       w_set_ferr;
  logic                       w_set_perr;
  logic                       w_parity_bad;

  // START samples at half a bit; every later sample is one full bit on.
  assign w_tick = (r_state == ST_START) ? (r_cnt == HALF_M1) : (r_cnt == BIT_M1);

`ifdef UART_RX_PARITY_EN
  logic r_parity_bit;
  logic w_parity_ld;

  assign w_parity_bad = even_parity_bad(r_shift, r_parity_bit);
`else
  assign w_parity_bad = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement leaves a signal unassigned and infers a latch.
    w_next_state = r_state;
    w_cnt_clr    = 1'b1;
    w_shift_en   = 1'b0;
    w_set_valid  = 1'b0;
    w_set_ferr   = 1'b0;
    w_set_perr   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parity_ld  = 1'b0;
`endif

    unique case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) w_next_state = ST_START;
      end

      ST_START: begin
        w_cnt_clr = w_tick;
        if (w_tick) begin
          // Line back high by mid-start-bit: a glitch, drop it silently.
          w_next_state = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        w_cnt_clr = w_tick;
        if (w_tick) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            w_next_state = ST_PARITY;
`else
            w_next_state = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        w_cnt_clr = w_tick;
        if (w_tick) begin
          w_parity_ld  = 1'b1;
          w_next_state = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        w_cnt_clr = w_tick;
        if (w_tick) begin
          if (!w_rx_s) begin
            // Stop-bit error wins over any parity error.
            w_set_ferr   = 1'b1;
            w_next_state = ST_WAIT_HIGH;
          end else if (w_parity_bad) begin
            w_set_perr   = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_set_valid  = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
      end

      // A held-low break must return high before a new start bit is accepted.
      ST_WAIT_HIGH: begin
        if (w_rx_s) w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bit-period counter and bit index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
    end else begin
      // Also cleared on every state change, so each state starts counting at 0.
      if (w_cnt_clr || (w_next_state != r_state)) r_cnt <= '0;
      else                                         r_cnt <= r_cnt + CNT_W'(1);

      // The 3-bit index wraps 7 -> 0 on its own after the last data bit.
      if (r_state != ST_DATA) r_bit_idx <= '0;
      else if (w_shift_en)    r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Shift register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_frame_error  <= 1'b0;
      r_parity_error <= 1'b0;
    end else begin
      if (w_shift_en) r_shift[r_bit_idx] <= w_rx_s;
      if (w_set_valid) r_rx_data <= r_shift;
      r_rx_valid     <= w_set_valid;
      r_frame_error  <= w_set_ferr;
      r_parity_error <= w_set_perr;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_parity_bit <= 1'b0;
    else if (w_parity_ld) r_parity_bit <= w_rx_s;
  end
`endif

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign frame_error  = r_frame_error;
  assign parity_error = r_parity_error;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receive-side counterpart of the design's 8N1 transmitter. Synchronises the asynchronous serial line, detects and qualifies the start bit, and samples 8 data bits LSB-first at mid-bit. Checks the stop bit and presents the byte with a one-cycle valid strobe to the command/decode logic. Baud set by `CLKS_PER_BIT`: 50 MHz / 9600 baud = 5208.

## Interface
- `CLKS_PER_BIT`, default 5208: system clocks per serial bit. Legal range is ≥ 4.
- `clk`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx`  in  1  serial line, asynchronous. Idles high.
- `rx_data`  out  8  last good byte. Updated only with `rx_valid`; reset 0x00.
- `rx_valid`  out  1  one-cycle pulse when a good frame completes; reset 0.
- `frame_error`  out  1  one-cycle pulse when the stop bit is sampled low; reset 0.
- `parity_error`  out  1  one-cycle pulse on a parity mismatch; reset 0. Constant 0 without the macro.
- `busy`  out  1  high in every state except IDLE; reset 0.

## Operation
- `rx` passes through a 2-flop synchroniser, with both flops reset to 1; all logic uses `rx_s`.
- `HALF = CLKS_PER_BIT/2`, integer division.
- Counter width is `$clog2(CLKS_PER_BIT)`. The counter resets to 0 on every state transition.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE:
  - `rx_s`=0 → START, counter=0.
- START:
  - Count to `HALF-1`, then sample.
  - `rx_s`=0 → DATA with bit_index=0.
  - `rx_s`=1 → IDLE (glitch rejected; no output pulse).
- DATA:
  - Count to `CLKS_PER_BIT-1`, then shift `rx_s` into shift_reg[bit_index]. The sample lands at the centre of each bit.
  - bit_index wraps 7 → 0, then go to PARITY (macro) or STOP.
- STOP:
  - Count to `CLKS_PER_BIT-1`, then sample.
  - `rx_s`=1, no parity error → `rx_data`←shift_reg, `rx_valid`=1, → IDLE.
  - `rx_s`=0 → `frame_error`=1, `rx_data` unchanged, → WAIT_HIGH.
- WAIT_HIGH:
  - Stay until `rx_s`=1, then → IDLE. A held-low break therefore never produces a spurious frame.
- The FSM never stalls on the consumer. There is no backpressure; a byte not taken on `rx_valid` is overwritten by the next frame.
- Reset mid-frame: return to IDLE at once; all outputs go to their reset values and the partial byte is discarded.
- Unreachable state encoding → IDLE.

## Timing
- Synchroniser latency: 2 cycles.
- From the first `clk` edge where `rx` is low to the STOP sample: 2 + `HALF` + 9·`CLKS_PER_BIT` cycles, ±1. Add `CLKS_PER_BIT` with parity.
- `rx_valid`, `frame_error` and `parity_error` are registered, high for exactly one cycle, and mutually exclusive.
- `rx_data` is stable from the `rx_valid` cycle until the next `rx_valid`.
- Back-to-back frames: after a good STOP the FSM is in IDLE one cycle later, i.e. about half a bit before the stop bit ends. It accepts a start bit arriving straight after the stop bit with no gap cycles.
- Tolerates ±2% baud mismatch, since every sample is at mid-bit.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - One even-parity bit is expected after bit 7 and sampled in PARITY.
  - If XOR(data, parity bit) is 1, `parity_error` pulses at the STOP sample instead of `rx_valid`, and `rx_data` is not updated.
  - A stop-bit error takes precedence: `frame_error` only.
- Undefined: 8N1; the PARITY state is absent and `parity_error` is tied 0.
- Must match the transmitter's build.

## Structure
- Shared package `uart_pkg`: FSM state enum, `DEFAULT_CLKS_PER_BIT = 5208`, and the frame-format constants (`DATA_BITS = 8`). Shared with the transmitter.
- One sub-module, `sync_2ff` (parameterised reset value), reusable by other asynchronous inputs. The FSM, counter and shift register stay in `uart_rx`.

## Test plan
Bench uses `CLKS_PER_BIT=16` and drives frames from a bit-accurate model.
- Send 0xA5 in 8N1 → exactly one `rx_valid` with `rx_data`=0xA5; `frame_error`=0; `busy` falls after STOP.
- Send 0x00 then 0xFF back-to-back, no idle gap → two `rx_valid` pulses, data 0x00 then 0xFF, no errors.
- 4-cycle low glitch on idle line → no pulse, `busy` returns to 0 within `HALF`+3 cycles, `rx_data` unchanged.
- Send 0x3C with the stop bit forced low and the line held low for 40 cycles → one `frame_error`, no `rx_valid`, `rx_data` holds the previous value. The next good frame 0x5A is received correctly.
- Assert `rst_n`=0 during bit 4 of 0x81, release, then send 0x7E → only 0x7E is reported, no error pulses.
- With `UART_RX_PARITY_EN`:
  - Send 0x03 with parity bit 0 → `rx_valid`, data 0x03.
  - Send 0x03 with parity bit 1 → `parity_error` pulse, no `rx_valid`.
